eth_tx_arb: RTL and testbench



---
 rtl/eth_pkg.sv | 15 +
 rtl/eth_rr_pick.sv | 25 ++
 rtl/eth_tx_arb.sv | 150 +++++++++++++++
 tb/tb_eth_tx_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: arbiter state encoding,
// frame-size limit and AXI-Stream beat field widths.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ETH_MAX_FRAME = 1518;
  localparam int AXIS_DATA_W   = 8;
  localparam int AXIS_USER_W   = 1;

endpackage

// File: rtl/eth_rr_pick.sv
// Two-requester winner selection: fixed priority to port 0, or alternating
// preference relative to the previously granted port.
module eth_rr_pick
  import eth_pkg::*;
#(
  parameter bit PRIO_P0 = 1'b1
) (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any = |valid;
    if (PRIO_P0) begin
      winner = ~valid[0];
    end else if (valid[~last_grant]) begin
      winner = ~last_grant;
    end else begin
      winner = last_grant;
    end
  end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular arbiter sharing the MAC transmit stream between two sources,
// with forced truncation of over-length frames and per-port frame counters.
module eth_tx_arb
  import eth_pkg::*;
#(
  parameter bit PRIO_P0 = 1'b1,
  parameter int MAX_LEN = ETH_MAX_FRAME,
  parameter int CNT_W   = 16
) (
  input  logic                   tx_mac_aclk,
  input  logic                   tx_rst,
  input  logic                   en,
  input  logic [AXIS_DATA_W-1:0] s0_tdata,
  input  logic                   s0_tvalid,
  input  logic                   s0_tlast,
  input  logic [AXIS_USER_W-1:0] s0_tuser,
  output logic                   s0_tready,
  input  logic [AXIS_DATA_W-1:0] s1_tdata,
  input  logic                   s1_tvalid,
  input  logic                   s1_tlast,
  input  logic [AXIS_USER_W-1:0] s1_tuser,
  output logic                   s1_tready,
  output logic [AXIS_DATA_W-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  output logic [AXIS_USER_W-1:0] m_tuser,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   grant,
  output logic [CNT_W-1:0]       pkt_cnt0,
  output logic [CNT_W-1:0]       pkt_cnt1,
  output logic [7:0]             trunc_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [7:0]       trunc_cnt_q, trunc_cnt_d;

  logic                   pick_winner;
  logic                   pick_any;
  logic [AXIS_DATA_W-1:0] sel_tdata;
  logic                   sel_tvalid;
  logic                   sel_tlast;
  logic [AXIS_USER_W-1:0] sel_tuser;
  logic                   sel_ready;
  logic                   at_limit;

  eth_rr_pick #(
    .PRIO_P0 (PRIO_P0)
  ) u_pick (
    .valid      ({s1_tvalid, s0_tvalid}),
    .last_grant (grant_q),
    .winner     (pick_winner),
    .any        (pick_any)
  );

  assign sel_tdata  = grant_q ? s1_tdata  : s0_tdata;
  assign sel_tvalid = grant_q ? s1_tvalid : s0_tvalid;
  assign sel_tlast  = grant_q ? s1_tlast  : s0_tlast;
  assign sel_tuser  = grant_q ? s1_tuser  : s0_tuser;
  assign at_limit   = (len_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    len_d       = len_q;
    pkt_cnt0_d  = pkt_cnt0_q;
    pkt_cnt1_d  = pkt_cnt1_q;
    trunc_cnt_d = trunc_cnt_q;
    m_tdata     = sel_tdata;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = '0;
    sel_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          grant_d = pick_winner;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        m_tvalid  = sel_tvalid;
        m_tlast   = sel_tlast | at_limit;
        // A limit beat without source tlast is closed as an aborted frame.
        m_tuser   = sel_tuser | {AXIS_USER_W{at_limit & ~sel_tlast}};
        sel_ready = m_tready;
        if (sel_tvalid && m_tready) begin
          len_d = len_q + 16'd1;
          if (sel_tlast) begin
            if (grant_q) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
            else         pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
            len_d   = '0;
            state_d = ST_IDLE;
          end else if (at_limit) begin
            if (trunc_cnt_q != 8'hFF) trunc_cnt_d = trunc_cnt_q + 8'd1;
            len_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        sel_ready = 1'b1;
        if (sel_tvalid && sel_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are held quiet for the whole reset interval.
    if (tx_rst) begin
      m_tvalid  = 1'b0;
      m_tlast   = 1'b0;
      m_tuser   = '0;
      sel_ready = 1'b0;
    end
  end

  always_ff @(posedge tx_mac_aclk) begin
    if (tx_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= 1'b1;
      len_q       <= '0;
      pkt_cnt0_q  <= '0;
      pkt_cnt1_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      pkt_cnt0_q  <= pkt_cnt0_d;
      pkt_cnt1_q  <= pkt_cnt1_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign s0_tready = sel_ready & ~grant_q;
  assign s1_tready = sel_ready &  grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = grant_q;
  assign pkt_cnt0  = pkt_cnt0_q;
  assign pkt_cnt1  = pkt_cnt1_q;
  assign trunc_cnt = trunc_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: two instances (round-robin/full length and
// priority/16-beat limit) driven by the same randomized scenario sequence.
`timescale 1ns/1ps
module tb_eth_tx_arb;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int GI = gi;
    localparam bit PR = (gi == 1);
    localparam int ML = (gi == 0) ? 1518 : 16;

    logic        rst, en, m_tready;
    logic [7:0]  sd0, sd1, m_tdata;
    logic        sv0, sv1, sl0, sl1, su0, su1, sr0, sr1;
    logic        m_tvalid, m_tlast, m_tuser, busy, grant;
    logic [15:0] pc0, pc1;
    logic [7:0]  tc;

    beat_t q0[$];
    beat_t q1[$];
    beat_t st0[$];
    beat_t st1[$];
    int    fl0[$];
    int    fl1[$];
    beat_t exp_q[$];
    bit    gaps, bp, quiet1;
    int    beats_out;
    int    exp_pc0, exp_pc1, exp_tc;

    eth_tx_arb #(.PRIO_P0(PR), .MAX_LEN(ML), .CNT_W(16)) u_dut (
      .tx_mac_aclk (clk),      .tx_rst    (rst),       .en        (en),
      .s0_tdata    (sd0),      .s0_tvalid (sv0),       .s0_tlast  (sl0),
      .s0_tuser    (su0),      .s0_tready (sr0),
      .s1_tdata    (sd1),      .s1_tvalid (sv1),       .s1_tlast  (sl1),
      .s1_tuser    (su1),      .s1_tready (sr1),
      .m_tdata     (m_tdata),  .m_tvalid  (m_tvalid),  .m_tlast   (m_tlast),
      .m_tuser     (m_tuser),  .m_tready  (m_tready),  .busy      (busy),
      .grant       (grant),    .pkt_cnt0  (pc0),       .pkt_cnt1  (pc1),
      .trunc_cnt   (tc)
    );

    task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
        errors++;
        $display("FAIL g%0d %s: got %0d want %0d", GI, name, got, want);
      end
    endtask

    // Reference model: a frame of len beats leaves as at most ML beats; the
    // ML-th beat closes the frame, flagged aborted unless it was the real end.
    task automatic push_frame(input int port, input int len, input bit rand_user);
      beat_t b, e;
      int n = 0;
      for (int i = 0; i < len; i++) begin
        b.d = 8'($urandom);
        b.l = (i == len - 1);
        b.u = rand_user ? ($urandom_range(0, 7) == 0) : 1'b0;
        if (port == 0) q0.push_back(b); else q1.push_back(b);
        e = b;
        if (i == ML - 1) begin
          e.l = 1'b1;
          if (!b.l) e.u = 1'b1;
        end
        if (i < ML) begin
          if (port == 0) st0.push_back(e); else st1.push_back(e);
          n++;
        end
      end
      if (port == 0) fl0.push_back(n); else fl1.push_back(n);
      if (len > ML) exp_tc = (exp_tc < 255) ? exp_tc + 1 : 255;
      else if (port == 0) exp_pc0++;
      else exp_pc1++;
      $display("g%0d frame port %0d len %0d out %0d", GI, port, len, n);
    endtask

    task automatic release_frame(input int port);
      int n;
      n = (port == 0) ? fl0.pop_front() : fl1.pop_front();
      for (int i = 0; i < n; i++)
        exp_q.push_back((port == 0) ? st0.pop_front() : st1.pop_front());
    endtask

    task automatic wait_idle(input string name);
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk({name, "_pending"}, q0.size() + q1.size() + exp_q.size(), 0);
      repeat (3) @(negedge clk);
    endtask

    task automatic check_cnt(input string name);
      chk({name, "_pkt_cnt0"}, int'(pc0), exp_pc0);
      chk({name, "_pkt_cnt1"}, int'(pc1), exp_pc1);
      chk({name, "_trunc_cnt"}, int'(tc), exp_tc);
    endtask

    task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      q0.delete(); q1.delete(); st0.delete(); st1.delete();
      fl0.delete(); fl1.delete(); exp_q.delete();
      exp_pc0 = 0; exp_pc1 = 0; exp_tc = 0;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_grant", int'(grant), 1);
      check_cnt("rst");
    endtask

    // Source and sink driver: a beat is consumed when valid & ready was seen
    // at the preceding negedge; valid is held until that happens.
    initial begin : drv
      bit x0, x1;
      sv0 = 0; sv1 = 0; sd0 = 0; sd1 = 0; sl0 = 0; sl1 = 0; su0 = 0; su1 = 0;
      m_tready = 0;
      forever begin
        @(negedge clk);
        x0 = sv0 & sr0;
        x1 = sv1 & sr1;
        @(posedge clk);
        #1;
        if (x0 && q0.size() > 0) void'(q0.pop_front());
        if (x1 && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() == 0) sv0 = 1'b0;
        else if (!(sv0 && !x0)) sv0 = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (q0.size() > 0) {sd0, sl0, su0} = q0[0];
        if (q1.size() == 0) sv1 = 1'b0;
        else if (!(sv1 && !x1)) sv1 = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (q1.size() > 0) {sd1, sl1, su1} = q1[0];
        m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end

    initial begin : mon
      bit    pv, pr_, prst;
      beat_t pb, got, e;
      pv = 0; pr_ = 0; prst = 1; pb = '0;
      forever begin
        @(negedge clk);
        got = {m_tdata, m_tlast, m_tuser};
        if (rst) begin
          chk("rst_outputs", int'({m_tvalid, m_tlast, m_tuser, sr0, sr1}), 0);
        end else begin
          if (pv && !pr_ && !prst) begin
            checks++;
            if (!m_tvalid || got != pb) begin
              errors++;
              $display("FAIL g%0d hold: got v=%b beat=%h want v=1 beat=%h", GI, m_tvalid, got, pb);
            end
          end
          if (sr0 && sr1) begin
            errors++;
            $display("FAIL g%0d tready_both: got 11 want at most one", GI);
          end
          if (quiet1) chk("p1_tready_quiet", int'(sr1), 0);
          if (m_tvalid && m_tready) begin
            checks++;
            beats_out++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL g%0d beat_unexpected: got %h want none", GI, got);
            end else begin
              e = exp_q.pop_front();
              if (got != e) begin
                errors++;
                $display("FAIL g%0d beat: got d=%h l=%b u=%b want d=%h l=%b u=%b",
                         GI, got.d, got.l, got.u, e.d, e.l, e.u);
              end
            end
          end
        end
        pv = m_tvalid; pr_ = m_tready; pb = got; prst = rst;
      end
    end

    initial begin : scen
      int n, t, b0, bad, len;
      int len_tab[5];
      len_tab = '{1, 2, 15, 16, 17};
      rst = 1; en = 1; gaps = 0; bp = 0; quiet1 = 0; beats_out = 0;
      exp_pc0 = 0; exp_pc1 = 0; exp_tc = 0;

      // Single 64-beat frame on port 0: one-cycle bubble, port 1 idle.
      do_reset();
      quiet1 = 1;
      push_frame(0, 64, 0);
      release_frame(0);
      t = 0;
      while (!sv0 && t < 50) begin @(negedge clk); t++; end
      n = 0;
      while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
      chk("bubble", n, 1);
      wait_idle("s1");
      quiet1 = 0;
      check_cnt("s1");

      // Both ports continuously valid, three 10-beat frames each.
      do_reset();
      bp = 1;
      for (int i = 0; i < 3; i++) push_frame(0, 10, 1);
      for (int i = 0; i < 3; i++) push_frame(1, 10, 1);
      for (int i = 0; i < 6; i++) begin
        if (PR) release_frame((i < 3) ? 0 : 1);
        else    release_frame(i % 2);
      end
      wait_idle("s2");
      check_cnt("s2");
      bp = 0;

      // 20-beat frame on port 1 (truncated where the limit is 16).
      do_reset();
      push_frame(1, 20, 0);
      release_frame(1);
      wait_idle("s3");
      check_cnt("s3");

      // Backpressure and source gaps, then random frames around the limit.
      do_reset();
      bp = 1; gaps = 1;
      push_frame(0, 100, 1);
      release_frame(0);
      wait_idle("s4a");
      for (int i = 0; i < 10; i++) begin
        n = $urandom_range(0, 1);
        len = (i < 5) ? len_tab[i] : $urandom_range(1, 40);
        push_frame(n, len, 1);
        release_frame(n);
        wait_idle("s4b");
      end
      check_cnt("s4");
      bp = 0; gaps = 0;

      // en dropped mid-frame: frame completes, nothing new is granted.
      do_reset();
      push_frame(0, 30, 0);
      release_frame(0);
      b0 = beats_out; t = 0;
      while (beats_out - b0 < 3 && t < 500) begin @(negedge clk); #1; t++; end
      @(posedge clk);
      #2 en = 0;
      push_frame(1, 8, 0);
      release_frame(1);
      t = 0;
      while (q0.size() != 0 && t < 500) begin @(negedge clk); t++; end
      chk("en_frame_done", q0.size(), 0);
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (m_tvalid || busy) bad++;
      end
      chk("en_hold", bad, 0);
      chk("en_hold_q1", q1.size(), 8);
      en = 1;
      wait_idle("s5");
      check_cnt("s5");

      // Reset on beat 5 of a frame, then a clean frame afterwards.
      do_reset();
      push_frame(0, 40, 0);
      release_frame(0);
      b0 = beats_out; t = 0;
      while (beats_out - b0 < 5 && t < 500) begin @(negedge clk); #1; t++; end
      @(posedge clk);
      #2 rst = 1;
      @(negedge clk);
      chk("midrst_tvalid", int'(m_tvalid), 0);
      @(negedge clk);
      chk("midrst_busy", int'(busy), 0);
      q0.delete(); q1.delete(); exp_q.delete();
      exp_pc0 = 0; exp_pc1 = 0; exp_tc = 0;
      check_cnt("midrst");
      @(posedge clk);
      #2 rst = 0;
      push_frame(1, 12, 0);
      release_frame(1);
      wait_idle("s6");
      check_cnt("s6");

      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == 2);
      begin
        #500000;
        errors++;
        $display("FAIL timeout: got %0d finished instances want 2", done_cnt);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
